// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: synchronises 16 external lines, keeps edge/level pending state in CSRs
// and presents one fixed-priority request at a time to the trap unit (no nesting).
module interrupt_arbiter #(
  parameter logic [11:0] ADDRESS_BASE = 12'hBC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csrWriteEnable,
  input  logic        csrReadEnable,
  input  logic [11:0] csrWriteAddress,
  input  logic [11:0] csrReadAddress,
  input  logic [31:0] csrWriteData,
  output logic [31:0] csrReadData,
  output logic        requestOutput,
  input  logic [15:0] irq,
  input  logic        inTrap,
  input  logic        trapReturn,
  output logic [15:0] userInterrupts,
  output logic [4:0]  activeId
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, ACTIVE = 2'd2} state_t;

  state_t      state;
  logic [15:0] irqMeta, irqSync, irqSyncDly;
  logic [15:0] pending, irqEnable, irqEdge;
  logic [15:0] eligible, rise, swClear, trapClear, pendingNext;
  logic [3:0]  grantIdx, winnerIdx;
  logic [11:0] writeOffset, readOffset;
  logic        wrEnable, wrEdge, wrPending;
  logic [31:0] readData;
  logic        unusedWriteBits;

  // Offsets wrap modulo 4096 so a base near the top of the CSR space still decodes.
  assign writeOffset   = csrWriteAddress - ADDRESS_BASE;
  assign readOffset    = csrReadAddress - ADDRESS_BASE;
  assign wrEnable      = csrWriteEnable && (writeOffset == 12'd0);
  assign wrEdge        = csrWriteEnable && (writeOffset == 12'd1);
  assign wrPending     = csrWriteEnable && (writeOffset == 12'd2);
  assign requestOutput = csrReadEnable && (readOffset[11:2] == 10'd0);
  assign unusedWriteBits = ^csrWriteData[31:16];

  always_comb begin
    readData = '0;
    case (readOffset[1:0])
      2'd0:    readData = {16'h0, irqEnable};
      2'd1:    readData = {16'h0, irqEdge};
      2'd2:    readData = {16'h0, pending};
      default: readData = {27'h0, activeId};
    endcase
  end

  assign csrReadData = (requestOutput && rst) ? readData : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irqMeta    <= '0;
      irqSync    <= '0;
      irqSyncDly <= '0;
    end else begin
      irqMeta    <= irq;
      irqSync    <= irqMeta;
      irqSyncDly <= irqSync;
    end
  end

  // Edge bits latch rises and clear on W1C or on trap entry; a same-cycle rise wins.
  assign eligible    = pending & irqEnable;
  assign rise        = irqSync & ~irqSyncDly;
  assign swClear     = wrPending ? (csrWriteData[15:0] & irqEdge) : 16'h0;
  assign trapClear   = (state == REQUEST && inTrap) ? ((16'd1 << grantIdx) & irqEdge) : 16'h0;
  assign pendingNext = (irqEdge & (rise | (pending & ~(swClear | trapClear)))) |
                       (~irqEdge & irqSync);

  always_comb begin
    winnerIdx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (eligible[i]) winnerIdx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irqEnable <= '0;
      irqEdge   <= '0;
      pending   <= '0;
    end else begin
      if (wrEnable) irqEnable <= csrWriteData[15:0];
      if (wrEdge)   irqEdge   <= csrWriteData[15:0];
      pending <= pendingNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      grantIdx       <= '0;
      userInterrupts <= '0;
      activeId       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state          <= REQUEST;
            grantIdx       <= winnerIdx;
            userInterrupts <= 16'd1 << winnerIdx;
          end
        end
        REQUEST: begin
          // A trap already being taken outranks a line withdrawn in the same cycle.
          if (inTrap) begin
            state          <= ACTIVE;
            userInterrupts <= '0;
            activeId       <= {1'b1, grantIdx};
          end else if (!eligible[grantIdx]) begin
            state          <= IDLE;
            userInterrupts <= '0;
          end
        end
        ACTIVE: begin
          if (trapReturn) begin
            state    <= IDLE;
            activeId <= '0;
          end
        end
        default: begin
          state          <= IDLE;
          userInterrupts <= '0;
          activeId       <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_interrupt_arbiter.sv
// Bench for interrupt_arbiter: directed scenarios against fixed values, then random
// traffic against a cycle-level behavioural model of the arbiter rules.
module tb_interrupt_arbiter;
  localparam logic [11:0] BASE = 12'hBC0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csrWriteEnable = 1'b0;
  logic        csrReadEnable = 1'b0;
  logic [11:0] csrWriteAddress = 12'h0;
  logic [11:0] csrReadAddress = 12'h0;
  logic [31:0] csrWriteData = 32'h0;
  logic [31:0] csrReadData;
  logic        requestOutput;
  logic [15:0] irq = 16'h0;
  logic        inTrap = 1'b0;
  logic        trapReturn = 1'b0;
  logic [15:0] userInterrupts;
  logic [4:0]  activeId;

  int vectors = 0;
  int miscompares = 0;

  interrupt_arbiter #(.ADDRESS_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
    .csrWriteAddress(csrWriteAddress), .csrReadAddress(csrReadAddress),
    .csrWriteData(csrWriteData), .csrReadData(csrReadData),
    .requestOutput(requestOutput), .irq(irq), .inTrap(inTrap),
    .trapReturn(trapReturn), .userInterrupts(userInterrupts), .activeId(activeId)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: irqQ holds the last three sampled irq words (newest first).
  logic [15:0] irqQ[$];
  logic [15:0] mEn, mEdge, mPend;
  int          mMode;   // 0 idle, 1 requesting, 2 in service
  int          mGrant;

  function automatic void model_reset();
    irqQ = '{16'h0, 16'h0, 16'h0};
    mEn = 16'h0; mEdge = 16'h0; mPend = 16'h0;
    mMode = 0; mGrant = 0;
  endfunction

  function automatic void model_clock();
    logic [15:0] syncNow, syncOld, elig, np;
    logic        wrPend;
    syncNow = irqQ[1];
    syncOld = irqQ[2];
    elig    = mPend & mEn;
    wrPend  = csrWriteEnable && (csrWriteAddress == BASE + 12'd2);
    for (int i = 0; i < 16; i++) begin
      if (!mEdge[i])                            np[i] = syncNow[i];
      else if (syncNow[i] && !syncOld[i])       np[i] = 1'b1;
      else if ((wrPend && csrWriteData[i]) || (mMode == 1 && inTrap && mGrant == i)) np[i] = 1'b0;
      else                                      np[i] = mPend[i];
    end
    if (mMode == 0) begin
      for (int i = 15; i >= 0; i--) if (elig[i]) begin mMode = 1; mGrant = i; end
    end else if (mMode == 1) begin
      if (inTrap) mMode = 2;
      else if (!elig[mGrant]) mMode = 0;
    end else if (trapReturn) begin
      mMode = 0;
    end
    if (csrWriteEnable && csrWriteAddress == BASE)         mEn   = csrWriteData[15:0];
    if (csrWriteEnable && csrWriteAddress == BASE + 12'd1) mEdge = csrWriteData[15:0];
    mPend = np;
    irqQ.push_front(irq);
    void'(irqQ.pop_back());
  endfunction

  function automatic logic [15:0] exp_ui();
    logic [15:0] one;
    one = 16'd1;
    return (mMode == 1) ? (one << mGrant) : 16'h0;
  endfunction

  function automatic logic [4:0] exp_aid();
    logic [3:0] g;
    g = mGrant[3:0];
    return (mMode == 2) ? {1'b1, g} : 5'h0;
  endfunction

  function automatic logic exp_req();
    logic [11:0] off;
    off = csrReadAddress - BASE;
    return csrReadEnable && (off <= 12'd3);
  endfunction

  function automatic logic [31:0] exp_read();
    logic [11:0] off;
    off = csrReadAddress - BASE;
    if (!rst || !exp_req()) return 32'h0;
    case (off[1:0])
      2'd0:    return {16'h0, mEn};
      2'd1:    return {16'h0, mEdge};
      2'd2:    return {16'h0, mPend};
      default: return {27'h0, exp_aid()};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csrWriteEnable = 1'b1; csrWriteAddress = a; csrWriteData = d;
    tick();
    csrWriteEnable = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csrReadEnable = 1'b1; csrReadAddress = a;
    #1;
    d = csrReadData;
  endtask

  task automatic pulse(input logic [15:0] m);
    irq = irq | m;
    tick();
    irq = irq & ~m;
  endtask

  task automatic wait_for_ui(input int budget);
    int n;
    n = 0;
    while (userInterrupts === 16'h0 && n < budget) begin tick(); n++; end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    repeat (3) tick();
    vectors++; if (userInterrupts !== 16'h0) begin miscompares++; $display("FAIL reset_ui: got %h expected 0000", userInterrupts); end
    vectors++; if (activeId !== 5'h0) begin miscompares++; $display("FAIL reset_aid: got %h expected 00", activeId); end
    for (int k = 0; k < 4; k++) begin
      csr_read(BASE + 12'(k), d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_read%0d: got %h expected 0", k, d); end
    end
    rst = 1'b1;
    tick();
    csr_read(BASE + 12'd4, d);
    vectors++; if (requestOutput !== 1'b0 || d !== 32'h0) begin miscompares++; $display("FAIL unmapped_read: got req %b data %h expected req 0 data 0", requestOutput, d); end
    csr_read(BASE, d);
    vectors++; if (requestOutput !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL enable_after_reset: got req %b data %h expected req 1 data 0", requestOutput, d); end
    csrReadEnable = 1'b0;
    #1;
    vectors++; if (requestOutput !== 1'b0) begin miscompares++; $display("FAIL req_no_enable: got %b expected 0", requestOutput); end
  endtask

  task automatic test_edge_path();
    logic [31:0] d;
    csr_write(BASE, 32'h1);
    csr_write(BASE + 12'd1, 32'h1);
    pulse(16'h0001);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      vectors++; if (userInterrupts !== 16'h0) begin miscompares++; $display("FAIL edge_latency_c%0d: got %h expected 0000", c, userInterrupts); end
    end
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL edge_pending_set: got %h expected 1", d); end
    tick();
    vectors++; if (userInterrupts !== 16'h0001) begin miscompares++; $display("FAIL edge_request: got %h expected 0001", userInterrupts); end
    inTrap = 1'b1; tick(); inTrap = 1'b0;
    vectors++; if (activeId !== 5'h10 || userInterrupts !== 16'h0) begin miscompares++; $display("FAIL edge_active: got aid %h ui %h expected aid 10 ui 0000", activeId, userInterrupts); end
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL edge_pending_clr: got %h expected 0", d); end
    csr_read(BASE + 12'd3, d);
    vectors++; if (d !== 32'h10) begin miscompares++; $display("FAIL claim_read: got %h expected 10", d); end
    trapReturn = 1'b1; tick(); trapReturn = 1'b0;
    tick();
    vectors++; if (activeId !== 5'h0 || userInterrupts !== 16'h0) begin miscompares++; $display("FAIL edge_return: got aid %h ui %h expected 0 0", activeId, userInterrupts); end
  endtask

  task automatic test_priority();
    csr_write(BASE, 32'h24);
    csr_write(BASE + 12'd1, 32'h24);
    pulse(16'h0024);
    wait_for_ui(8);
    vectors++; if (userInterrupts !== 16'h0004) begin miscompares++; $display("FAIL prio_first: got %h expected 0004", userInterrupts); end
    inTrap = 1'b1; tick(); inTrap = 1'b0;
    vectors++; if (activeId !== 5'h12) begin miscompares++; $display("FAIL prio_active2: got %h expected 12", activeId); end
    trapReturn = 1'b1; tick(); trapReturn = 1'b0;
    tick();
    vectors++; if (userInterrupts !== 16'h0020) begin miscompares++; $display("FAIL prio_second: got %h expected 0020", userInterrupts); end
    inTrap = 1'b1; tick(); inTrap = 1'b0;
    vectors++; if (activeId !== 5'h15) begin miscompares++; $display("FAIL prio_active5: got %h expected 15", activeId); end
    trapReturn = 1'b1; tick(); trapReturn = 1'b0;
  endtask

  task automatic test_withdraw();
    csr_write(BASE, 32'h8);
    csr_write(BASE + 12'd1, 32'h0);
    irq[3] = 1'b1;
    wait_for_ui(8);
    vectors++; if (userInterrupts !== 16'h0008) begin miscompares++; $display("FAIL withdraw_req: got %h expected 0008", userInterrupts); end
    csr_write(BASE, 32'h0);
    tick();
    vectors++; if (userInterrupts !== 16'h0 || activeId !== 5'h0) begin miscompares++; $display("FAIL withdraw_drop: got ui %h aid %h expected 0 0", userInterrupts, activeId); end
    irq[3] = 1'b0;
    repeat (4) tick();
    vectors++; if (userInterrupts !== 16'h0) begin miscompares++; $display("FAIL withdraw_idle: got %h expected 0000", userInterrupts); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    csr_write(BASE, 32'h0);
    csr_write(BASE + 12'd1, 32'h2);
    pulse(16'h0002); tick(); tick();
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL coll_preset: got %h expected 2", d); end
    pulse(16'h0002); tick();
    csr_write(BASE + 12'd2, 32'h2);
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL coll_set_wins: got %h expected 2", d); end
    csr_write(BASE + 12'd2, 32'h2);
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL w1c_clear: got %h expected 0", d); end
    csr_write(BASE + 12'd1, 32'h0);
    irq[6] = 1'b1;
    repeat (3) tick();
    csr_write(BASE + 12'd2, 32'h40);
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h40) begin miscompares++; $display("FAIL level_ignores_w1c: got %h expected 40", d); end
    irq[6] = 1'b0;
    repeat (3) tick();
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL level_release: got %h expected 0", d); end
    csr_write(BASE, 32'hFFFF_1234);
    csr_write(BASE + 12'd3, 32'hFFFF_FFFF);
    csr_read(BASE, d);
    vectors++; if (d !== 32'h1234) begin miscompares++; $display("FAIL enable_width: got %h expected 1234", d); end
    csr_read(BASE + 12'd3, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL claim_readonly: got %h expected 0", d); end
    csr_write(BASE, 32'h0);
  endtask

  task automatic test_no_nesting();
    csr_write(BASE, 32'h11);
    csr_write(BASE + 12'd1, 32'h11);
    pulse(16'h0010);
    wait_for_ui(8);
    vectors++; if (userInterrupts !== 16'h0010) begin miscompares++; $display("FAIL nest_req4: got %h expected 0010", userInterrupts); end
    inTrap = 1'b1; tick(); inTrap = 1'b0;
    vectors++; if (activeId !== 5'h14) begin miscompares++; $display("FAIL nest_active4: got %h expected 14", activeId); end
    pulse(16'h0001);
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++; if (userInterrupts !== 16'h0) begin miscompares++; $display("FAIL nest_blocked_c%0d: got %h expected 0000", c, userInterrupts); end
    end
    trapReturn = 1'b1; tick(); trapReturn = 1'b0;
    tick();
    vectors++; if (userInterrupts !== 16'h0001) begin miscompares++; $display("FAIL nest_after_return: got %h expected 0001", userInterrupts); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    inTrap = 1'b1; tick(); inTrap = 1'b0;
    vectors++; if (activeId !== 5'h10) begin miscompares++; $display("FAIL areset_pre: got %h expected 10", activeId); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++; if (userInterrupts !== 16'h0 || activeId !== 5'h0) begin miscompares++; $display("FAIL areset_immediate: got ui %h aid %h expected 0 0", userInterrupts, activeId); end
    csr_read(BASE + 12'd3, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL areset_read: got %h expected 0", d); end
    tick(); tick();
    rst = 1'b1;
    repeat (2) tick();
    csr_read(BASE + 12'd3, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL areset_claim: got %h expected 0", d); end
    csr_read(BASE, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL areset_enable: got %h expected 0", d); end
    csr_read(BASE + 12'd2, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL areset_pending: got %h expected 0", d); end
  endtask

  task automatic test_random();
    logic [15:0] elig;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 16; i++) if ($urandom_range(0, 15) == 0) irq[i] = ~irq[i];
      csrWriteEnable  = ($urandom_range(0, 7) == 0);
      csrWriteAddress = BASE + 12'($urandom_range(0, 4));
      csrWriteData    = $urandom;
      elig       = mPend & mEn;
      inTrap     = ($urandom_range(0, 3) == 0);
      if (mMode == 1 && !elig[mGrant]) inTrap = 1'b0;
      trapReturn = ($urandom_range(0, 3) == 0);
      csrReadEnable  = ($urandom_range(0, 3) != 0);
      csrReadAddress = BASE + 12'($urandom_range(0, 5));
      #1;
      vectors++; if (requestOutput !== exp_req() || csrReadData !== exp_read()) begin
        miscompares++; $display("FAIL rand_read c%0d addr %h: got req %b data %h expected req %b data %h", c, csrReadAddress, requestOutput, csrReadData, exp_req(), exp_read());
      end
      tick();
      vectors++; if (userInterrupts !== exp_ui() || activeId !== exp_aid()) begin
        miscompares++; $display("FAIL rand_out c%0d: got ui %h aid %h expected ui %h aid %h", c, userInterrupts, activeId, exp_ui(), exp_aid());
      end
    end
    csrWriteEnable = 1'b0; inTrap = 1'b0; trapReturn = 1'b0; csrReadEnable = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_edge_path();
    test_priority();
    test_withdraw();
    test_collision();
    test_no_nesting();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
